multiword_add_seq: RTL and testbench
====================================

Name: multiword_add_seq

Overview:
- Sequencer that performs WORDS×32-bit add or subtract by time-multiplexing one 32-bit Prefix_adder instance, least significant word first.
- Carry is chained between words through a carry register.
- Valid/ready on both the operand side and the result side.
- Sits between a wide-arithmetic requester (e.g. crypto or bignum unit) and the shared 32-bit prefix adder.

Parameters:
- WORDS, 4, number of 32-bit words per operand; legal range 2..16.

Ports:
- clk  input  1  clock; all state changes on rising edge
- rst_n  input  1  reset; synchronous, active-low
- in_valid  input  1  operand request valid
- in_ready  output  1  block can accept an operand request
- in_a  input  WORDS*32  operand A; word k is bits [32k+31:32k]
- in_b  input  WORDS*32  operand B
- in_cin  input  1  carry-in for word 0 (add only)
- in_sub  input  1  1 = A−B, 0 = A+B+cin
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- out_sum  output  WORDS*32  result
- out_cout  output  1  carry out of the top word; for subtract, 1 = no borrow
- busy  output  1  high in RUN or DONE

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is synchronous and active-low.
- Reset state: rst_n=0 at an edge forces state=IDLE, idx=0, carry=0, out_sum=0, out_cout=0, out_valid=0, busy=0. in_ready=1 on the first cycle after reset is released.
- Reset mid-operation: any in-flight operation is discarded, with no partial output.
- States:
  - IDLE: in_ready=1. On in_valid&&in_ready, latch a_r=in_a. Latch b_r=in_sub ? ~in_b : in_b. Set carry=in_sub ? 1 : in_cin, set idx=0, go to RUN.
  - RUN: Adder inputs are a_r word idx, b_r word idx and carry. Each edge writes the adder sum into result word idx, carry←cout, idx←idx+1. When idx==WORDS-1, also write out_cout←cout and go to DONE.
  - DONE: out_valid=1. out_sum and out_cout are held stable. On out_valid&&out_ready, go to IDLE.
- in_ready is 0 in RUN and DONE. in_valid in those states is ignored and its operands are not sampled.
- No same-cycle accept in DONE. Throughput is one operation per WORDS+2 cycles with out_ready=1.
- Latency: out_valid rises exactly WORDS cycles after the accepting edge. WORDS=4 gives 4 cycles.
- idx width is $clog2(WORDS). idx never exceeds WORDS-1 and never wraps inside an operation.
- Arithmetic: the result is modulo 2^(WORDS*32). Subtract is computed as A + ~B + 1, and in_cin is ignored when in_sub=1.
- out_sum words below idx may update during RUN, but out_sum is only defined while out_valid=1.
- A held out_valid with out_ready=0 keeps every output constant indefinitely.

Decomposition:
- Package add_seq_pkg holds:
  - localparam WORD_W=32
  - typedef enum logic [1:0] {IDLE, RUN, DONE} seq_state_t
  - a function word_sel(vector, idx) returning a WORD_W slice
- One sub-module: the existing Prefix_adder (32-bit a, b, cin → s, cout), instantiated once. No other sub-modules.

Test Plan:
All cases use WORDS=4.
1. in_a=128'hFFFF…FFFF (all ones), in_b=128'h1, cin=0, sub=0 → out_sum=128'h0, out_cout=1. out_valid rises exactly 4 cycles after accept.
2. in_a=128'h0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFF, in_b=128'h1 → out_sum=128'h0000_0000_0000_0001_0000_0000_0000_0000, out_cout=0. This checks carry crossing word boundaries.
3. in_a=128'h5, in_b=128'h7, sub=1 → out_sum=128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFE, out_cout=0 (borrow). Then in_a=7, in_b=5, sub=1 → out_sum=128'h2, out_cout=1.
4. in_a=4×32'h12345678, in_b=4×32'h87654321, cin=1 → out_sum=128'h99999999_99999999_99999999_9999999A, out_cout=0.
5. Backpressure: hold out_ready=0 for 6 cycles after out_valid. Meanwhile drive in_valid=1 with new operands → out_valid, out_sum and out_cout stay stable, in_ready=0, and the new operands are not taken. With out_ready=1, the handshake completes, the next cycle is IDLE, and in_ready=1.
6. Reset mid-RUN: drive rst_n=0 for one edge when idx=2 → next cycle out_valid=0, busy=0, in_ready=1, out_sum=0. A following test-1 operation then completes correctly.

Source files
------------

// File: rtl/add_seq_pkg.sv
// ---------------------------------------------------------------------------
// add_seq_pkg
// Shared definitions for the multi-word add/subtract sequencer:
//   WORD_W      - width of one arithmetic word (the shared adder width)
//   MAX_WORDS   - largest supported operand length in words
//   seq_state_t - sequencer FSM encoding
//   word_sel()  - extracts one WORD_W slice from a zero-extended operand
// ---------------------------------------------------------------------------
package add_seq_pkg;

    localparam int WORD_W    = 32;
    localparam int MAX_WORDS = 16;
    localparam int MAX_VEC_W = WORD_W * MAX_WORDS;
    localparam int SEL_W     = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_t;

    // Callers zero-extend their operand to MAX_VEC_W so one function serves
    // every WORDS setting.
    function automatic logic [WORD_W-1:0] word_sel(
        input logic [MAX_VEC_W-1:0] vec,
        input logic [SEL_W-1:0]     idx
    );
        return vec[idx*WORD_W +: WORD_W];
    endfunction

endpackage

// File: rtl/multiword_add_seq_prefix_adder.sv
// ---------------------------------------------------------------------------
// Prefix_adder
// 32-bit Kogge-Stone parallel-prefix adder.
// Ports:
//   a, b  - 32-bit addends
//   cin   - carry into bit 0
//   s     - 32-bit sum
//   cout  - carry out of bit 31
// ---------------------------------------------------------------------------
module Prefix_adder
    import add_seq_pkg::*;
(
    input  logic [WORD_W-1:0] a,
    input  logic [WORD_W-1:0] b,
    input  logic              cin,
    output logic [WORD_W-1:0] s,
    output logic              cout
);

    // Returns {cout, sum}. cin is folded into bit 0's generate term so the
    // prefix tree yields the true carry into every bit position.
    function automatic logic [WORD_W:0] ks_add(
        input logic [WORD_W-1:0] x,
        input logic [WORD_W-1:0] y,
        input logic              ci
    );
        logic [WORD_W-1:0] g;
        logic [WORD_W-1:0] p;
        logic [WORD_W-1:0] gn;
        logic [WORD_W-1:0] pn;
        logic [WORD_W-1:0] p0;
        logic [WORD_W-1:0] c;
        g    = x & y;
        p    = x ^ y;
        p0   = p;
        g[0] = g[0] | (p[0] & ci);
        for (int d = 1; d < WORD_W; d = d * 2) begin
            gn = g;
            pn = p;
            for (int i = d; i < WORD_W; i++) begin
                gn[i] = g[i] | (p[i] & g[i-d]);
                pn[i] = p[i] & p[i-d];
            end
            g = gn;
            p = pn;
        end
        c = {g[WORD_W-2:0], ci};
        return {g[WORD_W-1], p0 ^ c};
    endfunction

    logic [WORD_W:0] res_s;

    // Combinational prefix addition.
    always_comb begin
        res_s = ks_add(a, b, cin);
    end

    assign s    = res_s[WORD_W-1:0];
    assign cout = res_s[WORD_W];

endmodule

// File: rtl/multiword_add_seq.sv
// ---------------------------------------------------------------------------
// multiword_add_seq
// Performs WORDS x 32-bit add or subtract by feeding one 32-bit Prefix_adder
// one word per cycle, least significant word first, chaining the carry.
// Ports:
//   clk, rst_n          - clock, synchronous active-low reset
//   in_valid/in_ready   - operand handshake
//   in_a, in_b          - operands (word k at bits [32k+31:32k])
//   in_cin              - carry-in for add (ignored for subtract)
//   in_sub              - 1: A-B, 0: A+B+cin
//   out_valid/out_ready - result handshake
//   out_sum, out_cout   - result and top carry (subtract: 1 = no borrow)
//   busy                - high while an operation is in RUN or DONE
// ---------------------------------------------------------------------------
module multiword_add_seq
    import add_seq_pkg::*;
#(
    parameter int WORDS = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [WORDS*WORD_W-1:0] in_a,
    input  logic [WORDS*WORD_W-1:0] in_b,
    input  logic                    in_cin,
    input  logic                    in_sub,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WORDS*WORD_W-1:0] out_sum,
    output logic                    out_cout,
    output logic                    busy
);

    localparam int VEC_W = WORDS * WORD_W;
    localparam int IDX_W = $clog2(WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    seq_state_t         state_r;
    logic [IDX_W-1:0]   idx_r;
    logic               carry_r;
    logic [VEC_W-1:0]   a_r;
    logic [VEC_W-1:0]   b_r;

    logic [MAX_VEC_W-1:0] a_ext_s;
    logic [MAX_VEC_W-1:0] b_ext_s;
    logic [SEL_W-1:0]     idx_ext_s;
    logic [WORD_W-1:0]    add_a_s;
    logic [WORD_W-1:0]    add_b_s;
    logic [WORD_W-1:0]    sum_s;
    logic                 cout_s;

    // Select the current word of each latched operand for the shared adder.
    always_comb begin
        a_ext_s               = '0;
        b_ext_s               = '0;
        idx_ext_s             = '0;
        a_ext_s[VEC_W-1:0]    = a_r;
        b_ext_s[VEC_W-1:0]    = b_r;
        idx_ext_s[IDX_W-1:0]  = idx_r;
        add_a_s               = word_sel(a_ext_s, idx_ext_s);
        add_b_s               = word_sel(b_ext_s, idx_ext_s);
    end

    Prefix_adder u_adder (
        .a    (add_a_s),
        .b    (add_b_s),
        .cin  (carry_r),
        .s    (sum_s),
        .cout (cout_s)
    );

    // Sequencer FSM with registered handshake and result outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            idx_r     <= '0;
            carry_r   <= 1'b0;
            a_r       <= '0;
            b_r       <= '0;
            out_sum   <= '0;
            out_cout  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        // Subtract is A + ~B + 1: invert B and force carry-in.
                        a_r      <= in_a;
                        b_r      <= in_sub ? ~in_b : in_b;
                        carry_r  <= in_sub ? 1'b1 : in_cin;
                        idx_r    <= '0;
                        state_r  <= RUN;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                RUN: begin
                    for (int k = 0; k < WORDS; k++) begin
                        if (idx_r == IDX_W'(k)) begin
                            out_sum[k*WORD_W +: WORD_W] <= sum_s;
                        end
                    end
                    carry_r <= cout_s;
                    if (idx_r == LAST_IDX) begin
                        out_cout  <= cout_s;
                        out_valid <= 1'b1;
                        state_r   <= DONE;
                    end else begin
                        idx_r <= idx_r + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                        idx_r     <= '0;
                        state_r   <= IDLE;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    idx_r     <= '0;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multiword_add_seq.sv
// ---------------------------------------------------------------------------
// tb_multiword_add_seq
// Directed, table-driven bench for multiword_add_seq with WORDS=4, plus
// hand-written backpressure and mid-operation reset sequences.
// ---------------------------------------------------------------------------
module tb_multiword_add_seq;

    localparam int W = 128;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_cin;
    logic         in_sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_cout;
    logic         busy;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         sub;
        logic [W-1:0] exp_sum;
        logic         exp_cout;
    } vec_t;

    vec_t vecs [10];

    multiword_add_seq #(.WORDS(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .in_sub    (in_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Apply one operation, wait for the result, check it, then complete the
    // output handshake.
    task automatic do_op(input vec_t v, input string name);
        int lat;
        @(negedge clk);
        check({name, " in_ready_idle"}, {127'd0, in_ready}, 128'd1);
        in_a      = v.a;
        in_b      = v.b;
        in_cin    = v.cin;
        in_sub    = v.sub;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_a     = '0;
        in_b     = '0;
        lat      = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if (out_valid) break;
        end
        check({name, " latency"}, 128'(lat), 128'd4);
        check({name, " sum"}, out_sum, v.exp_sum);
        check({name, " cout"}, {127'd0, out_cout}, {127'd0, v.exp_cout});
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({name, " valid_drop"}, {127'd0, out_valid}, 128'd0);
        check({name, " ready_back"}, {127'd0, in_ready}, 128'd1);
    endtask

    initial begin
        vec_t v1;
        logic [W-1:0] held_sum;
        logic         held_cout;

        // {a, b, cin, sub, expected sum, expected cout}
        vecs[0] = '{{128{1'b1}}, 128'h1, 1'b0, 1'b0, 128'h0, 1'b1};
        vecs[1] = '{128'h0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFF, 128'h1, 1'b0, 1'b0,
                    128'h0000_0000_0000_0001_0000_0000_0000_0000, 1'b0};
        vecs[2] = '{128'h5, 128'h7, 1'b0, 1'b1,
                    128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFE, 1'b0};
        vecs[3] = '{128'h7, 128'h5, 1'b0, 1'b1, 128'h2, 1'b1};
        vecs[4] = '{{4{32'h12345678}}, {4{32'h87654321}}, 1'b1, 1'b0,
                    128'h99999999_99999999_99999999_9999999A, 1'b0};
        vecs[5] = '{128'h0, 128'h0, 1'b1, 1'b0, 128'h1, 1'b0};
        vecs[6] = '{128'h0, 128'h0, 1'b0, 1'b1, 128'h0, 1'b1};
        vecs[7] = '{128'hA, 128'h3, 1'b1, 1'b1, 128'h7, 1'b1};
        vecs[8] = '{128'h8000_0000_0000_0000_0000_0000_0000_0000,
                    128'h8000_0000_0000_0000_0000_0000_0000_0000, 1'b0, 1'b0, 128'h0, 1'b1};
        vecs[9] = '{128'h0000_0001_0000_0000_0000_0000_0000_0000, 128'h1, 1'b0, 1'b1,
                    128'h0000_0000_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 1'b1};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_cin    = 1'b0;
        in_sub    = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst out_valid", {127'd0, out_valid}, 128'd0);
        check("rst busy", {127'd0, busy}, 128'd0);
        check("rst in_ready", {127'd0, in_ready}, 128'd1);
        check("rst out_sum", out_sum, 128'd0);
        check("rst out_cout", {127'd0, out_cout}, 128'd0);

        for (int i = 0; i < 10; i++) begin
            do_op(vecs[i], $sformatf("vec%0d", i));
        end

        // Backpressure: result held, new operands ignored while in DONE.
        @(negedge clk);
        in_a = vecs[4].a; in_b = vecs[4].b; in_cin = 1'b1; in_sub = 1'b0;
        in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        #1;
        check("bp busy_run", {127'd0, busy}, 128'd1);
        in_a = vecs[0].a; in_b = vecs[0].b; in_cin = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) break;
        end
        held_sum  = out_sum;
        held_cout = out_cout;
        check("bp sum", held_sum, vecs[4].exp_sum);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("bp hold_valid%0d", i), {127'd0, out_valid}, 128'd1);
            check($sformatf("bp hold_sum%0d", i), out_sum, vecs[4].exp_sum);
            check($sformatf("bp hold_cout%0d", i), {127'd0, out_cout}, {127'd0, held_cout});
            check($sformatf("bp in_ready%0d", i), {127'd0, in_ready}, 128'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("bp idle_ready", {127'd0, in_ready}, 128'd1);
        check("bp idle_busy", {127'd0, busy}, 128'd0);
        check("bp idle_valid", {127'd0, out_valid}, 128'd0);
        repeat (2) @(posedge clk);
        #1;
        check("bp no_accept", {127'd0, busy}, 128'd0);

        // Reset in RUN with idx=2 discards the operation.
        v1 = vecs[0];
        @(negedge clk);
        in_a = v1.a; in_b = v1.b; in_cin = 1'b0; in_sub = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("mid_rst out_valid", {127'd0, out_valid}, 128'd0);
        check("mid_rst busy", {127'd0, busy}, 128'd0);
        check("mid_rst in_ready", {127'd0, in_ready}, 128'd1);
        check("mid_rst out_sum", out_sum, 128'd0);
        repeat (6) @(posedge clk);
        #1;
        check("mid_rst no_output", {127'd0, out_valid}, 128'd0);
        do_op(vecs[0], "post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
